cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_pkg.sv | 27 ++
 rtl/cpu_cycle_counter.sv | 54 +++++
 rtl/cpu_run_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_pkg
// Shared types and constants for the CPU run controller.
//   run_state_t : controller FSM states
//   MODE_*      : run-mode encodings carried on the Mode input
//   norm_mode() : folds the reserved mode (2'b11) onto run-N
// ---------------------------------------------------------------------------
package cpu_run_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    RUN   = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } run_state_t;

  localparam logic [1:0] MODE_RUNN = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // The reserved encoding behaves exactly like run-N.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_RUNN : m;
  endfunction

endpackage

// File: rtl/cpu_cycle_counter.sv
// ---------------------------------------------------------------------------
// cpu_cycle_counter
// W-bit enable/clear counter with terminal compare and sticky wrap flag.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset (count and wrap to 0)
//   i_clr      : synchronous clear, wins over i_en
//   i_en       : increment this cycle
//   i_term     : terminal value compared against the incremented count
//   o_count    : current count
//   o_inc      : count + 1 (modulo 2^W)
//   o_at_term  : this cycle's increment lands exactly on i_term
//   o_wrap     : sticky, set when an increment rolls over from all-ones
// ---------------------------------------------------------------------------
module cpu_cycle_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_inc,
  output logic         o_at_term,
  output logic         o_wrap
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;
  logic         r_wrap;

  assign o_count   = r_count;
  assign o_inc     = r_count + ONE;
  assign o_at_term = i_en && (o_inc == i_term);
  assign o_wrap    = r_wrap;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (i_en) begin
      r_count <= o_inc;
      if (r_count == '1) begin
        r_wrap <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
// Run controller for the 24-bit CPU: sequences CPU reset, then grants CPU
// clock-enable cycles in run-N, free-run or single-step mode, counting every
// granted cycle.
// Optional feature macro: BREAK_CYCLE_EN (adds BreakCycle / BreakHit; a RUN
// that reaches BreakCycle drops into STEP).
// Ports:
//   Clock      : clock, rising edge
//   Reset_n    : synchronous active-low reset, forces IDLE
//   Start      : pulse, launches a run from IDLE or DONE
//   Mode       : 00 run-N, 01 free-run, 10 step, 11 as 00 (sampled on Start)
//   RunCycles  : run-N budget, 0 selects DEFAULT_RUN (sampled on Start)
//   Step       : pulse, grants one CPU cycle in STEP
//   Halt       : level, ends any run at the next edge
//   BreakCycle : (BREAK_CYCLE_EN) nonzero count at which RUN switches to STEP
//   BreakHit   : (BREAK_CYCLE_EN) one-cycle pulse on the break
//   CpuRst_n   : CPU reset, active low
//   CpuClkEn   : CPU clock enable
//   CycleCount : granted cycles since the reset phase ended
//   Busy       : RESET, RUN or STEP
//   Done       : DONE
//   Wrap       : sticky, CycleCount wrapped during this run
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int RST_CYCLES  = 4,
  parameter int DEFAULT_RUN = 30
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [CNT_W-1:0] RunCycles,
  input  logic             Step,
  input  logic             Halt,
`ifdef BREAK_CYCLE_EN
  input  logic [CNT_W-1:0] BreakCycle,
  output logic             BreakHit,
`endif
  output logic             CpuRst_n,
  output logic             CpuClkEn,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Busy,
  output logic             Done,
  output logic             Wrap
);

  localparam int               RST_W      = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_TERM   = RST_W'(RST_CYCLES);
  localparam logic [CNT_W-1:0] DEF_TARGET = CNT_W'(DEFAULT_RUN);

  run_state_t       r_state;
  run_state_t       w_state_next;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_target;
  logic             r_cpu_rst_n;
  logic             r_cpu_clk_en;
  logic             r_busy;
  logic             r_done;

  logic             w_start_acc;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_at_term;
  logic             w_rst_done;
  logic             w_break_match;
  logic             w_cpu_rst_n_next;
  logic             w_cpu_clk_en_next;

  logic [RST_W-1:0] w_rst_count;
  logic [RST_W-1:0] w_rst_inc;
  logic             w_rst_wrap;
  logic             w_unused;

  assign w_start_acc = Start && ((r_state == IDLE) || (r_state == DONE));
  // Every high CpuClkEn cycle outside the reset phase is a granted cycle.
  assign w_cnt_en    = r_cpu_clk_en && ((r_state == RUN) || (r_state == STEP));

  cpu_cycle_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk     (Clock),
    .i_rst_n   (Reset_n),
    .i_clr     (w_start_acc),
    .i_en      (w_cnt_en),
    .i_term    (r_target),
    .o_count   (CycleCount),
    .o_inc     (w_cnt_inc),
    .o_at_term (w_cnt_at_term),
    .o_wrap    (Wrap)
  );

  // Counts RESET cycles; fires on the last one.
  cpu_cycle_counter #(.W(RST_W)) u_rst_timer (
    .i_clk     (Clock),
    .i_rst_n   (Reset_n),
    .i_clr     (w_start_acc),
    .i_en      (r_state == RESET),
    .i_term    (RST_TERM),
    .o_count   (w_rst_count),
    .o_inc     (w_rst_inc),
    .o_at_term (w_rst_done),
    .o_wrap    (w_rst_wrap)
  );

  assign w_unused = ^{w_rst_count, w_rst_inc, w_rst_wrap, w_cnt_inc};

`ifdef BREAK_CYCLE_EN
  assign w_break_match = w_cnt_en && (BreakCycle != '0) && (w_cnt_inc == BreakCycle);
`else
  assign w_break_match = 1'b0;
`endif

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    w_state_next      = r_state;
    w_cpu_rst_n_next  = 1'b0;
    w_cpu_clk_en_next = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (Start) begin
          w_state_next = RESET;
        end
      end
      RESET: begin
        if (Halt) begin
          w_state_next = DONE;
        end else if (w_rst_done) begin
          w_state_next = (r_mode == MODE_STEP) ? STEP : RUN;
        end
      end
      RUN: begin
        // Halt beats the terminal count, which beats a break.
        if (Halt) begin
          w_state_next = DONE;
        end else if ((r_mode == MODE_RUNN) && w_cnt_at_term) begin
          w_state_next = DONE;
        end else if (w_break_match) begin
          w_state_next = STEP;
        end
      end
      STEP: begin
        if (Halt) begin
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    case (w_state_next)
      RUN, STEP: w_cpu_rst_n_next = 1'b1;
      // DONE keeps whatever the CPU reset was: low if halted during RESET.
      DONE:      w_cpu_rst_n_next = r_cpu_rst_n;
      default:   w_cpu_rst_n_next = 1'b0;
    endcase

    // A step grant only comes from a Step seen while already stepping.
    w_cpu_clk_en_next = (w_state_next == RESET) || (w_state_next == RUN) ||
                        ((r_state == STEP) && (w_state_next == STEP) && Step);
  end

  // Registered outputs and per-run configuration
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_mode       <= MODE_RUNN;
      r_target     <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_cpu_clk_en <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_cpu_rst_n  <= w_cpu_rst_n_next;
      r_cpu_clk_en <= w_cpu_clk_en_next;
      r_busy       <= (w_state_next == RESET) || (w_state_next == RUN) ||
                      (w_state_next == STEP);
      r_done       <= (w_state_next == DONE);
      if (w_start_acc) begin
        r_mode   <= norm_mode(Mode);
        r_target <= (RunCycles == '0) ? DEF_TARGET : RunCycles;
      end
    end
  end

`ifdef BREAK_CYCLE_EN
  logic r_break_hit;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_break_hit <= 1'b0;
    end else begin
      r_break_hit <= (r_state == RUN) && (w_state_next == STEP);
    end
  end

  assign BreakHit = r_break_hit;
`endif

  assign CpuRst_n = r_cpu_rst_n;
  assign CpuClkEn = r_cpu_clk_en;
  assign Busy     = r_busy;
  assign Done     = r_done;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
// Cycle vectors for the basic sequencing plus hand-written multi-cycle
// sequences. A second instance with CNT_W=4 shares the stimulus and is
// checked for counter wrap.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, step, halt;
  logic [1:0]  mode;
  logic [15:0] rc;
  logic [3:0]  rc_s;
  assign rc_s = rc[3:0];

  logic        cpu_rst_n, clk_en, busy, done, wrap;
  logic [15:0] cnt;
  logic        cpu_rst_n_s, clk_en_s, busy_s, done_s, wrap_s;
  logic [3:0]  cnt_s;

`ifdef BREAK_CYCLE_EN
  logic [15:0] bc;
  logic [3:0]  bc_s;
  logic        bhit, bhit_s;
`endif

  cpu_run_ctrl #(.CNT_W(16), .RST_CYCLES(4), .DEFAULT_RUN(30)) u_dut (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Mode(mode), .RunCycles(rc),
    .Step(step), .Halt(halt),
`ifdef BREAK_CYCLE_EN
    .BreakCycle(bc), .BreakHit(bhit),
`endif
    .CpuRst_n(cpu_rst_n), .CpuClkEn(clk_en), .CycleCount(cnt),
    .Busy(busy), .Done(done), .Wrap(wrap)
  );

  cpu_run_ctrl #(.CNT_W(4), .RST_CYCLES(4), .DEFAULT_RUN(30)) u_small (
    .Clock(clk), .Reset_n(rst_n), .Start(start), .Mode(mode), .RunCycles(rc_s),
    .Step(step), .Halt(halt),
`ifdef BREAK_CYCLE_EN
    .BreakCycle(bc_s), .BreakHit(bhit_s),
`endif
    .CpuRst_n(cpu_rst_n_s), .CpuClkEn(clk_en_s), .CycleCount(cnt_s),
    .Busy(busy_s), .Done(done_s), .Wrap(wrap_s)
  );

  typedef struct {
    logic        rst_n, start;
    logic [1:0]  mode;
    logic [15:0] rc;
    logic        step, halt;
    logic        e_rstn, e_en, e_busy, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input logic r, s, input logic [1:0] m, input logic [15:0] c,
                              input logic st, h, er, ee, eb, ed, input logic [15:0] ec);
    vec_t v;
    v.rst_n = r; v.start = s; v.mode = m; v.rc = c; v.step = st; v.halt = h;
    v.e_rstn = er; v.e_en = ee; v.e_busy = eb; v.e_done = ed; v.e_cnt = ec;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {11'b0, cpu_rst_n, clk_en, busy, done, wrap, cnt};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0; mode = 2'b00; rc = 16'd0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [15:0] c);
    start = 1'b1; mode = m; rc = c;
    tick();
    start = 1'b0;
  endtask

  // Counts reset-phase and granted enable cycles from the current sample on.
  task automatic run_to_done(output int rlow, output int ehi, output logic to);
    rlow = 0; ehi = 0; to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!cpu_rst_n && clk_en) rlow++;
      if (cpu_rst_n && clk_en) ehi++;
      if (done) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  // Advances until the DUT has counted n granted cycles (sampled in the nth).
  task automatic count_enabled(input int n, output logic to);
    int k;
    k = 0; to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (cpu_rst_n && clk_en) k++;
      if (k == n) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_cnt(input logic [15:0] n, output logic to);
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (cnt == n && cpu_rst_n) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int   rlow, ehi, pulses;
    logic to;

    rst_n = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0; mode = 2'b00; rc = 16'd0;
`ifdef BREAK_CYCLE_EN
    bc = 16'd0; bc_s = 4'd0;
`endif

    // ---------------- vector table ------------------------------------
    //                r  s  m  rc  st h | rstn en busy done cnt
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));  // reset
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0));  // idle
    vecs.push_back(mk(1, 1, 0, 3,  0, 0,  0, 1, 1, 0, 0));  // start run-N 3
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  0, 1, 1, 0, 0));  // 4th reset cycle
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  1, 1, 1, 0, 0));  // RUN
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  1, 1, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 3,  0, 0,  1, 0, 0, 1, 3));  // DONE
    vecs.push_back(mk(1, 1, 2, 0,  1, 0,  0, 1, 1, 0, 0));  // restart, step mode
    vecs.push_back(mk(1, 0, 2, 0,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 2, 0,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 2, 0,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 2, 0,  0, 0,  1, 0, 1, 0, 0));  // STEP, idle
    vecs.push_back(mk(1, 0, 2, 0,  1, 0,  1, 1, 1, 0, 0));  // grant
    vecs.push_back(mk(1, 0, 2, 0,  0, 0,  1, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 2, 0,  1, 0,  1, 1, 1, 0, 1));  // step held 2
    vecs.push_back(mk(1, 0, 2, 0,  1, 0,  1, 1, 1, 0, 2));
    vecs.push_back(mk(1, 0, 2, 0,  0, 0,  1, 0, 1, 0, 3));
    vecs.push_back(mk(1, 0, 2, 0,  1, 1,  1, 0, 0, 1, 3));  // halt beats step
    vecs.push_back(mk(1, 1, 0, 5,  0, 1,  0, 1, 1, 0, 0));  // start in DONE
    vecs.push_back(mk(1, 0, 0, 5,  0, 1,  0, 0, 0, 1, 0));  // halt in RESET
    vecs.push_back(mk(1, 1, 3, 2,  0, 0,  0, 1, 1, 0, 0));  // reserved mode
    vecs.push_back(mk(1, 0, 3, 2,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 3, 2,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 3, 2,  0, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 3, 2,  0, 0,  1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 3, 2,  0, 0,  1, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 3, 2,  0, 0,  1, 0, 0, 1, 2));  // acts as run-N

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; start = vecs[i].start; mode = vecs[i].mode;
      rc = vecs[i].rc; step = vecs[i].step; halt = vecs[i].halt;
      tick();
      check($sformatf("vec%0d", i), outs(),
            {11'b0, vecs[i].e_rstn, vecs[i].e_en, vecs[i].e_busy, vecs[i].e_done,
             1'b0, vecs[i].e_cnt});
    end
    start = 1'b0; step = 1'b0; halt = 1'b0;

    // ---------------- run-N 30 ----------------------------------------
    reset_dut();
    pulse_start(2'b00, 16'd30);
    run_to_done(rlow, ehi, to);
    check("runN30_timeout", 32'(to), 32'd0);
    check("runN30_rst_cycles", 32'(rlow), 32'd4);
    check("runN30_en_cycles", 32'(ehi), 32'd30);
    check("runN30_count", 32'(cnt), 32'd30);

    // ---------------- default budget, relaunch from DONE ---------------
    pulse_start(2'b00, 16'd0);
    check("relaunch_cleared", {30'b0, cpu_rst_n, 1'b0} | 32'(cnt), 32'd0);
    run_to_done(rlow, ehi, to);
    check("default_timeout", 32'(to), 32'd0);
    check("default_en_cycles", 32'(ehi), 32'd30);
    check("default_count", 32'(cnt), 32'd30);

    // ---------------- spaced step pulses -------------------------------
    reset_dut();
    pulse_start(2'b10, 16'd0);
    wait_cnt(16'd0, to);
    check("step_enter_timeout", 32'(to), 32'd0);
    pulses = 0;
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick();
      pulses += int'(clk_en);
      step = 1'b0;
      for (int w = 0; w < 4; w++) begin
        tick();
        pulses += int'(clk_en);
      end
    end
    check("step_pulses", 32'(pulses), 32'd3);
    check("step_count", 32'(cnt), 32'd3);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("step_halt", {30'b0, done, clk_en}, 32'b10);

    // ---------------- free-run, halt after 100 -------------------------
    reset_dut();
    pulse_start(2'b01, 16'd0);
    count_enabled(100, to);
    check("free_timeout", 32'(to), 32'd0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("free_count", 32'(cnt), 32'd100);
    check("free_halt_state", {29'b0, clk_en, busy, done}, 32'b001);

    // ---------------- ignored Start, reset mid-run ---------------------
    reset_dut();
    pulse_start(2'b01, 16'd0);
    wait_cnt(16'd5, to);
    check("busy_wait_timeout", 32'(to), 32'd0);
    start = 1'b1; mode = 2'b00; rc = 16'd1;
    tick();
    start = 1'b0;
    check("start_ignored", {12'b0, cpu_rst_n, clk_en, busy, done, cnt}, {12'b0, 4'b1110, 16'd6});
    wait_cnt(16'd12, to);
    check("cnt12_timeout", 32'(to), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrun_reset", outs(), 32'd0);

    // ---------------- wrap on the 4-bit instance -----------------------
    reset_dut();
    pulse_start(2'b01, 16'd0);
    count_enabled(20, to);
    check("wrap_timeout", 32'(to), 32'd0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("wrap_small", {27'b0, wrap_s, cnt_s}, {27'b0, 1'b1, 4'd4});
    check("wrap_wide", {15'b0, wrap, cnt}, {15'b0, 1'b0, 16'd20});

`ifdef BREAK_CYCLE_EN
    // ---------------- break into STEP ----------------------------------
    reset_dut();
    bc = 16'd7;
    pulse_start(2'b00, 16'd30);
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (bhit) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    check("break_timeout", 32'(to), 32'd0);
    check("break_state", {12'b0, cpu_rst_n, clk_en, busy, done, cnt}, {12'b0, 4'b1010, 16'd7});
    tick();
    check("break_pulse_width", 32'(bhit), 32'd0);
    for (int p = 0; p < 2; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
    end
    check("break_steps", {15'b0, done, cnt}, {15'b0, 1'b0, 16'd9});
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("break_halt", 32'(done), 32'd1);
    bc = 16'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
